// File: rtl/cart_bus_capture.sv
// cart_bus_capture: passive capture of the N64 cartridge bus.
// Synchronises AD/ALEH/ALEL//RD, rebuilds the 32-bit address from the two
// ALE phases, pairs /RD strobes into 32-bit words and emits {addr, data}
// records downstream.
//
// Output handshake: a record is transferred on every clk where
// cap_valid=1 and cap_ready=1. While cap_valid=1 and cap_ready=0,
// cap_addr/cap_data hold steady. A word completing while the output
// register is still occupied and not being drained is dropped and
// err_overflow is set (sticky until reset).
module cart_bus_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cart_ad,
  input  logic        cart_rd,
  input  logic        cart_alel,
  input  logic        cart_aleh,
  output logic        cap_valid,
  input  logic        cap_ready,
  output logic [31:0] cap_addr,
  output logic [31:0] cap_data,
  output logic [15:0] cap_count,
  output logic        err_overflow,
  output logic        err_partial,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_H  = 3'd1,
    S_ADDR_L  = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4
  } state_t;

  // Synchroniser chain, bit layout {aleh, alel, rd, ad[15:0]}
  logic [18:0] sync_q [SYNC_STAGES];

  logic        aleh_s;
  logic        alel_s;
  logic        rd_s;
  logic [15:0] ad_s;

  // Previous synchronised samples for edge detection
  logic aleh_p_q;
  logic alel_p_q;
  logic rd_p_q;

  // Registered edge flags (one pipeline stage after the synchroniser)
  logic rd_rise_q;
  logic aleh_rise_q;
  logic aleh_fall_q;
  logic alel_fall_q;
  logic alel_at_fall_q;

  // Shadow registers holding the last stable bus sample of each phase
  logic [15:0] ad_hi_q;
  logic [15:0] ad_lo_q;
  logic [15:0] ad_dat_q;

  // FSM and assembly registers
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] lo_q, lo_d;
  logic        emit;
  logic        partial_set;

  // Output registers
  logic        cap_valid_q;
  logic [31:0] cap_addr_q;
  logic [31:0] cap_data_q;
  logic [15:0] cap_count_q;
  logic        err_overflow_q;
  logic        err_partial_q;

  assign {aleh_s, alel_s, rd_s, ad_s} = sync_q[SYNC_STAGES-1];

  // Input synchroniser: all four bus inputs see the same depth
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {cart_aleh, cart_alel, cart_rd, cart_ad};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Edge detection: current vs previous synchronised sample, then registered
  always_ff @(posedge clk) begin
    if (reset) begin
      aleh_p_q       <= 1'b0;
      alel_p_q       <= 1'b0;
      rd_p_q         <= 1'b0;
      rd_rise_q      <= 1'b0;
      aleh_rise_q    <= 1'b0;
      aleh_fall_q    <= 1'b0;
      alel_fall_q    <= 1'b0;
      alel_at_fall_q <= 1'b0;
    end else begin
      aleh_p_q       <= aleh_s;
      alel_p_q       <= alel_s;
      rd_p_q         <= rd_s;
      rd_rise_q      <= rd_s & ~rd_p_q;
      aleh_rise_q    <= aleh_s & ~aleh_p_q;
      aleh_fall_q    <= ~aleh_s & aleh_p_q;
      alel_fall_q    <= ~alel_s & alel_p_q;
      alel_at_fall_q <= alel_s;
    end
  end

  // Shadow registers track the bus while their qualifier holds, then freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      ad_hi_q  <= '0;
      ad_lo_q  <= '0;
      ad_dat_q <= '0;
    end else begin
      if (aleh_s && alel_s)  ad_hi_q  <= ad_s;
      if (alel_s && !aleh_s) ad_lo_q  <= ad_s;
      if (!rd_s)             ad_dat_q <= ad_s;
    end
  end

  // FSM state and assembly register update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
    end
  end

  // FSM next state, address/data assembly and emit decision
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lo_d        = lo_q;
    emit        = 1'b0;
    partial_set = 1'b0;

    case (state_q)
      S_IDLE: begin
      end
      S_ADDR_H: begin
        if (aleh_fall_q) begin
          if (alel_at_fall_q) begin
            state_d       = S_ADDR_L;
            addr_d[31:16] = ad_hi_q;
          end else begin
            // ALEL already gone: malformed address phase, drop silently
            state_d = S_IDLE;
          end
        end
      end
      S_ADDR_L: begin
        if (alel_fall_q) begin
          state_d      = S_DATA_LO;
          addr_d[15:0] = ad_lo_q;
        end
      end
      S_DATA_LO: begin
        if (rd_rise_q) begin
          state_d = S_DATA_HI;
          lo_d    = ad_dat_q;
        end
      end
      S_DATA_HI: begin
        if (rd_rise_q) begin
          // Burst reads continue at the next word without a new address
          emit    = 1'b1;
          addr_d  = addr_q + 32'd4;
          state_d = S_DATA_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new address phase overrides everything; a completing word in the
    // same cycle is emitted first and does not count as partial.
    if (aleh_rise_q) begin
      state_d = S_ADDR_H;
      if (state_q == S_DATA_HI && !rd_rise_q) partial_set = 1'b1;
    end
  end

  // Output record register, record counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid_q    <= 1'b0;
      cap_addr_q     <= '0;
      cap_data_q     <= '0;
      cap_count_q    <= '0;
      err_overflow_q <= 1'b0;
      err_partial_q  <= 1'b0;
    end else begin
      if (emit) begin
        if (!cap_valid_q || cap_ready) begin
          cap_valid_q <= 1'b1;
          cap_addr_q  <= addr_q;
          cap_data_q  <= {ad_dat_q, lo_q};
          cap_count_q <= cap_count_q + 16'd1;
        end else begin
          err_overflow_q <= 1'b1;
        end
      end else if (cap_valid_q && cap_ready) begin
        cap_valid_q <= 1'b0;
      end
      if (partial_set) err_partial_q <= 1'b1;
    end
  end

  assign cap_valid    = cap_valid_q;
  assign cap_addr     = cap_addr_q;
  assign cap_data     = cap_data_q;
  assign cap_count    = cap_count_q;
  assign err_overflow = err_overflow_q;
  assign err_partial  = err_partial_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cart_bus_capture.sv
// tb_cart_bus_capture: directed bench for cart_bus_capture.
module tb_cart_bus_capture;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DATA_HI = 3'd4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] cart_ad;
  logic        cart_rd;
  logic        cart_alel;
  logic        cart_aleh;
  logic        cap_valid;
  logic        cap_ready;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic [15:0] cap_count;
  logic        err_overflow;
  logic        err_partial;
  logic [2:0]  dbg_state;

  cart_bus_capture #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .cart_ad      (cart_ad),
    .cart_rd      (cart_rd),
    .cart_alel    (cart_alel),
    .cart_aleh    (cart_aleh),
    .cap_valid    (cap_valid),
    .cap_ready    (cap_ready),
    .cap_addr     (cap_addr),
    .cap_data     (cap_data),
    .cap_count    (cap_count),
    .err_overflow (err_overflow),
    .err_partial  (err_partial),
    .dbg_state    (dbg_state)
  );

  // Scoreboard
  int          tests = 0;
  int          fails = 0;
  int          exp_count = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  // Records accepted by the downstream side, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset && cap_valid && cap_ready) got_q.push_back({cap_addr, cap_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Driver tasks: pins change 1 ns after a rising edge
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a);
    cart_ad   = a[31:16];
    cart_alel = 1'b1;
    cart_aleh = 1'b1;
    clks(10);
    cart_aleh = 1'b0;
    clks(2);
    cart_ad = a[15:0];
    clks(10);
    cart_alel = 1'b0;
    clks(10);
  endtask

  task automatic rd_low(input logic [15:0] d);
    cart_ad = d;
    cart_rd = 1'b0;
    clks(10);
  endtask

  task automatic rd_high();
    cart_rd = 1'b1;
    clks(10);
  endtask

  task automatic pulse(input logic [15:0] d);
    rd_low(d);
    rd_high();
  endtask

  task automatic expect_rec(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
    exp_count++;
  endtask

  task automatic check_records(input string tag);
    check({tag, "_nrec"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_rec"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    check({tag, "_count"}, 64'(cap_count), 64'(exp_count[15:0]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(cap_valid), 64'h0);
    check({tag, "_addr"}, 64'(cap_addr), 64'h0);
    check({tag, "_data"}, 64'(cap_data), 64'h0);
    check({tag, "_count"}, 64'(cap_count), 64'h0);
    check({tag, "_ovf"}, 64'(err_overflow), 64'h0);
    check({tag, "_partial"}, 64'(err_partial), 64'h0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    int lat;

    // Reset with the bus idle (/RD high, ALEs low)
    reset     = 1'b1;
    cart_ad   = 16'h0000;
    cart_rd   = 1'b1;
    cart_alel = 1'b0;
    cart_aleh = 1'b0;
    cap_ready = 1'b1;
    clks(4);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    clks(6);
    check_reset_outputs("after_reset");

    // Single read with latency measurement on the completing /RD rise
    addr_phase(32'h1000_0000);
    pulse(16'h0037);
    rd_low(16'h1240);
    check("single_pending", 64'(cap_valid), 64'h0);
    expect_rec(32'h1000_0000, 32'h1240_0037);
    cart_rd = 1'b1;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cap_valid && lat < 0) lat = i;
    end
    check("single_latency", 64'(lat), 64'd4);
    clks(4);
    check_records("single");

    // Back-to-back reads; the last word waits for /RD to return high
    addr_phase(32'h1000_0040);
    pulse(16'h1234);
    pulse(16'hABCD);
    expect_rec(32'h1000_0040, 32'hABCD_1234);
    addr_phase(32'h1000_0044);
    pulse(16'h0102);
    pulse(16'hA5B9);
    expect_rec(32'h1000_0044, 32'hA5B9_0102);
    addr_phase(32'h1000_0048);
    pulse(16'h9900);
    rd_low(16'h7788);
    clks(10);
    check_records("b2b");
    check("b2b_last_held", 64'(cap_valid), 64'h0);
    check("b2b_state", 64'(dbg_state), 64'(ST_DATA_HI));
    expect_rec(32'h1000_0048, 32'h7788_9900);
    rd_high();
    check_records("b2b_last");

    // Burst: one address phase, four strobes
    addr_phase(32'h1000_0100);
    pulse(16'h1111);
    pulse(16'h2222);
    expect_rec(32'h1000_0100, 32'h2222_1111);
    pulse(16'h3333);
    pulse(16'h4444);
    expect_rec(32'h1000_0104, 32'h4444_3333);
    check_records("burst");

    // Backpressure: second word dropped while the first is held
    cap_ready = 1'b0;
    addr_phase(32'h1000_0200);
    pulse(16'h0001);
    pulse(16'h0002);
    expect_rec(32'h1000_0200, 32'h0002_0001);
    check("bp_ovf_before", 64'(err_overflow), 64'h0);
    pulse(16'h0003);
    pulse(16'h0004);
    check("bp_valid", 64'(cap_valid), 64'h1);
    check("bp_addr", 64'(cap_addr), 64'h1000_0200);
    check("bp_data", 64'(cap_data), 64'h0002_0001);
    check("bp_ovf", 64'(err_overflow), 64'h1);
    check("bp_count", 64'(cap_count), 64'(exp_count[15:0]));
    cap_ready = 1'b1;
    clks(2);
    check("bp_drained", 64'(cap_valid), 64'h0);
    check_records("bp");

    // Abort: new address phase with one halfword pending
    addr_phase(32'h1000_0300);
    pulse(16'hDEAD);
    check("abort_partial_before", 64'(err_partial), 64'h0);
    addr_phase(32'h1000_0400);
    check("abort_partial", 64'(err_partial), 64'h1);
    check("abort_valid", 64'(cap_valid), 64'h0);
    check_records("abort_none");
    pulse(16'h5678);
    pulse(16'h9ABC);
    expect_rec(32'h1000_0400, 32'h9ABC_5678);
    check_records("abort_next");
    check("abort_ovf_sticky", 64'(err_overflow), 64'h1);

    // One-cycle reset while a halfword is pending
    addr_phase(32'h1000_0500);
    pulse(16'h1111);
    check("rst_pre_state", 64'(dbg_state), 64'(ST_DATA_HI));
    reset = 1'b1;
    clks(1);
    reset = 1'b0;
    exp_count = 0;
    clks(1);
    check_reset_outputs("mid_reset");
    pulse(16'h2222);
    pulse(16'h3333);
    clks(4);
    check_records("post_reset");
    check("post_reset_state", 64'(dbg_state), 64'(ST_IDLE));

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cart_bus_capture.md
# cart_bus_capture

Passive capture stage for the N64 cartridge parallel bus (multiplexed AD[15:0], ALEH, ALEL, /RD). Sits directly behind the cartridge connector pins:
- synchronises the asynchronous bus into the FPGA clock domain;
- reconstructs the 32-bit bus address from the two ALE phases;
- assembles each pair of /RD strobes into a 32-bit data word;
- presents {address, data} records on a valid/ready interface to the logging/compare logic downstream.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser applied identically to cart_ad, cart_rd, cart_alel, cart_aleh (min 2).
- clk  in  1  system clock (≥50 MHz; every bus phase ≥100 ns is sampled ≥5 times).
- reset  in  1  synchronous, active-high reset.
- cart_ad  in  16  multiplexed address/data bus (asynchronous).
- cart_rd  in  1  /RD strobe, low = data phase (asynchronous).
- cart_alel  in  1  address latch enable, low half (asynchronous).
- cart_aleh  in  1  address latch enable, high half (asynchronous).
- cap_valid  out  1  capture record available.
- cap_ready  in  1  downstream accepts record when high with cap_valid.
- cap_addr  out  32  address of captured word.
- cap_data  out  32  captured word, {second halfword, first halfword}.
- cap_count  out  16  number of records emitted, wraps at 0xFFFF→0.
- err_overflow  out  1  sticky: record dropped because output register occupied.
- err_partial  out  1  sticky: ALEH rose with one halfword pending.

## Operation
- All four bus inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised copies: current vs previous sample.
- Shadow registers are updated each clk from synchronised cart_ad:
  - ad_hi while aleh_s=1 and alel_s=1;
  - ad_lo while alel_s=1 and aleh_s=0;
  - ad_dat while rd_s=0.
- Shadow registers freeze when their qualifier drops. They hold the last stable sample, so bus turnaround after an edge is never captured.
- FSM states: IDLE, ADDR_H, ADDR_L, DATA_LO, DATA_HI.
  - Any state, aleh_s rising → ADDR_H. If the state was DATA_HI, set err_partial and discard the pending halfword.
  - ADDR_H, aleh_s falling while alel_s=1 → ADDR_L; addr[31:16] ← ad_hi.
  - ADDR_H, aleh_s falling while alel_s=0 → IDLE (malformed, no flag).
  - ADDR_L, alel_s falling → DATA_LO; addr[15:0] ← ad_lo.
  - DATA_LO, rd_s rising → DATA_HI; data[15:0] ← ad_dat.
  - DATA_HI, rd_s rising → emit record {addr, {ad_dat, data[15:0]}}; addr ← addr+4 (32-bit wrap); → DATA_LO, so burst reads continue without a new address phase.
  - IDLE, ADDR_H and ADDR_L ignore rd_s edges. IDLE ignores everything except an aleh_s rise.
- Emit rules:
  - If cap_valid=0, or cap_ready=1 in the same cycle: load cap_addr/cap_data, cap_valid←1, cap_count+1.
  - Otherwise drop the new record, keep the old one, set err_overflow.
- cap_valid clears on cap_valid&cap_ready when no emit occurs in that cycle.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - cap_valid=0, cap_addr=0, cap_data=0, cap_count=0;
  - err_overflow=0, err_partial=0;
  - FSM=IDLE;
  - synchroniser and shadow registers all 0 (rd sync = 0, so a post-reset high /RD produces one rising edge, ignored in IDLE).
- Reset mid-transaction aborts it. The next record requires a fresh ALEH rise.
- Latency: cap_valid rises SYNC_STAGES+2 clk after the pin-level /RD rising edge that completes the word (sync, edge detect, output register).
- A word completes only on the second /RD rise. The final /RD low of a transaction stays pending until /RD returns high, which normally happens at the start of the next access.
- Simultaneous rd_s rise and aleh_s rise in DATA_HI: emit first, then go to ADDR_H; err_partial is not set.
- cap_addr/cap_data are stable while cap_valid=1 and cap_ready=0.

## Test plan
- Single read: address 0x1000_0000, halfwords 0x0037 then 0x1240, followed by the leading /RD rise of the next access → exactly one record: addr 0x1000_0000, data 0x1240_0037; cap_count=1.
- Back-to-back reads at 0x1000_0040 (0xABCD_1234), 0x1000_0044 (0xA5B9_0102) and 0x1000_0048 (0x7788_9900), with cap_ready=1:
  - records for 0x40 and 0x44 appear in order;
  - 0x48 is not emitted until /RD is driven high.
- Burst: one address phase at 0x1000_0100, then four /RD pulses (0x1111, 0x2222, 0x3333, 0x4444) → 0x1000_0100:0x2222_1111, then 0x1000_0104:0x4444_3333.
- Backpressure: hold cap_ready=0 across two completed words → first record held unchanged, err_overflow=1, cap_count=1. Raising cap_ready clears cap_valid.
- Abort: ALEH rises after a single /RD pulse → err_partial=1, no record. The following full read captures correctly.
- Reset asserted for 1 clk during DATA_HI → all outputs return to reset values. /RD rises before the next ALEH produce no record.
